ifm_in_fsm: RTL and testbench
=============================

# ifm_in_fsm

Receive-side frame writer for the 10G Ethernet core. It accepts the MAC receive AXI-Stream, which has no tready and cannot be back-pressured, and writes each frame into the 73-bit data FIFO as {tlast, tkeep, tdata}. When a frame ends it writes one 64-bit descriptor into the ctrl FIFO. It admits, drops or truncates frames according to FIFO space, and is the producer-side counterpart of the FIFO reader that drives the MAC transmit stream.

## Interface
Parameters:
- C_MAX_LEN, 16'd9600: byte count above which a frame is flagged oversize.

Ports:
- rx_clk  in  1  sole clock; all logic is on its rising edge.
- rx_reset  in  1  synchronous, active-high reset.
- rx_axis_mac_tdata  in  64  receive data; byte 0 is in [7:0].
- rx_axis_mac_tkeep  in  8  byte enables, contiguous from bit 0.
- rx_axis_mac_tvalid  in  1  beat valid; there is no ready signal.
- rx_axis_mac_tlast  in  1  last beat of the frame.
- rx_axis_mac_tuser  in  1  sampled on the tlast beat: 1 = good frame, 0 = FCS or other error.
- data_fifo_wdata  out  73  {tlast, tkeep, tdata}.
- data_fifo_wren  out  1  data FIFO write strobe.
- data_fifo_full  in  1  asserted when 1 or fewer entries are free.
- data_fifo_afull  in  1  asserted when fewer than C_MAX_LEN/8+2 entries are free.
- ctrl_fifo_wdata  out  64  frame descriptor.
- ctrl_fifo_wren  out  1  ctrl FIFO write strobe.
- ctrl_fifo_afull  in  1  asserted when 1 or fewer entries are free.
- rx_drop_cnt  out  32  count of frames dropped whole.
- rx_trunc_cnt  out  32  count of frames truncated.

## Operation
- Frame tracker: in_frame is set on a beat with tvalid & ~tlast and cleared on a beat with tvalid & tlast. SOF = tvalid & ~in_frame. This tracker runs in every state.
- States and transitions:
  - S_IDLE, on SOF:
    - admit if ~data_fifo_afull & ~ctrl_fifo_afull: write the beat, go to S_DATA (or straight to end-of-frame handling if tlast);
    - otherwise rx_drop_cnt++ and go to S_DROP (stay in S_IDLE if the beat is tlast).
  - S_DATA: each valid beat is written.
    - tlast beat written: schedule the descriptor, go to S_IDLE.
    - data_fifo_full on a valid beat: that beat is not written; go to S_TRUNC, or to S_TERM if the beat is tlast.
  - S_TRUNC: beats are discarded; on the tlast beat go to S_TERM.
  - S_TERM: wait for ~data_fifo_full.
    - Then write one terminator beat {1, 8'h00, 64'h0} and schedule a descriptor with truncated=1; rx_trunc_cnt++.
    - Exit to S_DROP if in_frame is set, otherwise to S_IDLE.
    - Every SOF seen while in S_TERM increments rx_drop_cnt.
  - S_DROP: beats are discarded; go to S_IDLE on the tlast beat.
- Byte count: 16 bits, adds popcount(tkeep) for each beat actually written, saturates at 16'hFFFF, and is cleared at each admitted SOF.
- Descriptor layout:
  - [15:0] byte count;
  - [16] good = registered tuser from the tlast beat (0 for truncated frames);
  - [17] truncated;
  - [18] oversize (byte count > C_MAX_LEN);
  - [31:19] zero;
  - [63:32] sequence number, which starts at 0 and increments per descriptor, wrapping at 2^32.
- Oversize frames are still written normally; only the flag is set.
- Drop and truncation counters wrap at 2^32.

## Timing
- Data write latency: data_fifo_wren and data_fifo_wdata are registered and assert 1 cycle after the input beat.
- Descriptor latency: ctrl_fifo_wren pulses for 1 cycle, in the cycle after the data write of the tlast or terminator beat (2 cycles after the input tlast beat in the normal case).
- Admission uses ctrl_fifo_afull, so a descriptor still pending from the previous frame can never overflow the ctrl FIFO.
- Back-to-back frames: a SOF in the cycle after tlast is admitted with no lost beat.
- Every state handles tlast and SOF arriving in the same beat (single-beat frames).
- Reset: state = S_IDLE, in_frame = 0. data_fifo_wren, ctrl_fifo_wren, both wdata buses, the byte count, the sequence number and both counters are all 0 in the cycle after rx_reset is sampled high.
- Reset mid-frame: abandon the frame with no terminator and no descriptor. After reset, beats are treated as SOF only once in_frame is rebuilt, so the tail of the abandoned frame is taken as a new frame.

## Test plan
- Normal frame: 60-byte frame in 8 beats, last tkeep 8'h0F, tuser=1 -> 8 data writes with the last beat's tlast=1; descriptor = {32'd0, 13'd0, 3'b001, 16'd60} with wren 2 cycles after the input tlast.
- Back-to-back single-beat frames: tkeep 8'hFF, tlast=1, tuser=0 on consecutive cycles -> 2 data writes and 2 descriptors with byte count 8, good=0, sequence numbers 0 and 1.
- Admission drop: data_fifo_afull=1 at SOF of a 10-beat frame -> no writes, rx_drop_cnt=1; the next frame with afull=0 is written whole.
- Truncation: data_fifo_full raised on beat 4 of 10, released 3 cycles after the input tlast -> beats 1-3 written, then terminator {1, 8'h00, 0}; descriptor byte count 24, truncated=1, good=0; rx_trunc_cnt=1.
- Frame during S_TERM: a new SOF arrives while the FIFO is still full -> rx_drop_cnt increments; after the terminator the FSM sits in S_DROP until that frame's tlast, and the following frame is written normally.
- Oversize: 9608-byte frame with C_MAX_LEN=9600 -> all 1201 beats written; descriptor oversize=1, byte count 9608.

Source files
------------

// File: rtl/ifm_in_fsm.sv
// Receive-side frame writer: turns the MAC receive stream into {tlast, tkeep, tdata} data FIFO
// entries plus one 64-bit descriptor per frame, dropping or truncating frames when the FIFOs fill.
module ifm_in_fsm #(
    parameter logic [15:0] C_MAX_LEN = 16'd9600
) (
    input  logic        rx_clk,
    input  logic        rx_reset,
    input  logic [63:0] rx_axis_mac_tdata,
    input  logic [7:0]  rx_axis_mac_tkeep,
    input  logic        rx_axis_mac_tvalid,
    input  logic        rx_axis_mac_tlast,
    input  logic        rx_axis_mac_tuser,
    output logic [72:0] data_fifo_wdata,
    output logic        data_fifo_wren,
    input  logic        data_fifo_full,
    input  logic        data_fifo_afull,
    output logic [63:0] ctrl_fifo_wdata,
    output logic        ctrl_fifo_wren,
    input  logic        ctrl_fifo_afull,
    output logic [31:0] rx_drop_cnt,
    output logic [31:0] rx_trunc_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DATA  = 3'd1;
    localparam logic [2:0] S_TRUNC = 3'd2;
    localparam logic [2:0] S_TERM  = 3'd3;
    localparam logic [2:0] S_DROP  = 3'd4;

    localparam logic [72:0] TERM_BEAT = {1'b1, 8'h00, 64'h0};

    logic [2:0]  state_reg, state_next;
    logic        in_frame_reg, in_frame_next;
    logic        sof;

    logic        beat_wr;
    logic        term_wr;
    logic        clear_cnt;
    logic        desc_sched;
    logic        desc_trunc;
    logic        drop_inc;
    logic        trunc_inc;

    logic [3:0]  keep_ext [8];
    logic [3:0]  keep_cnt;

    logic [15:0] byte_cnt_reg, byte_cnt_next;
    logic [15:0] byte_base;
    logic [16:0] byte_sum;

    logic        data_wren_reg, data_wren_next;
    logic [72:0] data_wdata_reg, data_wdata_next;

    logic        desc_pend_reg;
    logic        desc_trunc_reg;
    logic        good_reg, good_next;

    logic        ctrl_wren_reg, ctrl_wren_next;
    logic [63:0] ctrl_wdata_reg, ctrl_wdata_next;
    logic [31:0] seq_reg, seq_next;
    logic        oversize;

    logic [31:0] drop_cnt_reg, drop_cnt_next;
    logic [31:0] trunc_cnt_reg, trunc_cnt_next;

    // Frame tracker runs regardless of FSM state so SOF detection stays correct while discarding.
    assign sof           = rx_axis_mac_tvalid & ~in_frame_reg;
    assign in_frame_next = rx_axis_mac_tvalid ? ~rx_axis_mac_tlast : in_frame_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_keep_ext
            assign keep_ext[gi] = {3'b000, rx_axis_mac_tkeep[gi]};
        end
    endgenerate

    always_comb begin
        keep_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            keep_cnt = keep_cnt + keep_ext[i];
        end
    end

    always_comb begin
        state_next = state_reg;
        beat_wr    = 1'b0;
        term_wr    = 1'b0;
        clear_cnt  = 1'b0;
        desc_sched = 1'b0;
        desc_trunc = 1'b0;
        drop_inc   = 1'b0;
        trunc_inc  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (sof) begin
                    if (~data_fifo_afull & ~ctrl_fifo_afull) begin
                        beat_wr   = 1'b1;
                        clear_cnt = 1'b1;
                        if (rx_axis_mac_tlast) begin
                            desc_sched = 1'b1;
                        end else begin
                            state_next = S_DATA;
                        end
                    end else begin
                        drop_inc = 1'b1;
                        if (!rx_axis_mac_tlast) begin
                            state_next = S_DROP;
                        end
                    end
                end
            end
            S_DATA: begin
                if (rx_axis_mac_tvalid) begin
                    if (data_fifo_full) begin
                        state_next = rx_axis_mac_tlast ? S_TERM : S_TRUNC;
                    end else begin
                        beat_wr = 1'b1;
                        if (rx_axis_mac_tlast) begin
                            desc_sched = 1'b1;
                            state_next = S_IDLE;
                        end
                    end
                end
            end
            S_TRUNC: begin
                if (rx_axis_mac_tvalid & rx_axis_mac_tlast) begin
                    state_next = S_TERM;
                end
            end
            S_TERM: begin
                if (sof) begin
                    drop_inc = 1'b1;
                end
                if (~data_fifo_full) begin
                    term_wr    = 1'b1;
                    desc_sched = 1'b1;
                    desc_trunc = 1'b1;
                    trunc_inc  = 1'b1;
                    // A frame that began while waiting is still streaming and must be discarded.
                    state_next = in_frame_next ? S_DROP : S_IDLE;
                end
            end
            S_DROP: begin
                if (rx_axis_mac_tvalid & rx_axis_mac_tlast) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        byte_base     = clear_cnt ? 16'd0 : byte_cnt_reg;
        byte_sum      = {1'b0, byte_base} + {13'd0, keep_cnt};
        byte_cnt_next = byte_cnt_reg;
        if (beat_wr) begin
            byte_cnt_next = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
        end
    end

    always_comb begin
        data_wren_next  = beat_wr | term_wr;
        data_wdata_next = data_wdata_reg;
        if (term_wr) begin
            data_wdata_next = TERM_BEAT;
        end else if (beat_wr) begin
            data_wdata_next = {rx_axis_mac_tlast, rx_axis_mac_tkeep, rx_axis_mac_tdata};
        end
        good_next = good_reg;
        if (desc_sched) begin
            good_next = rx_axis_mac_tuser & ~desc_trunc;
        end
    end

    // Descriptor is built one cycle after the final data write, once the byte count has settled.
    assign oversize = (byte_cnt_reg > C_MAX_LEN);

    always_comb begin
        ctrl_wren_next  = desc_pend_reg;
        ctrl_wdata_next = ctrl_wdata_reg;
        seq_next        = seq_reg;
        if (desc_pend_reg) begin
            ctrl_wdata_next = {seq_reg, 13'd0, oversize, desc_trunc_reg,
                               good_reg & ~desc_trunc_reg, byte_cnt_reg};
            seq_next        = seq_reg + 32'd1;
        end
    end

    always_comb begin
        drop_cnt_next  = drop_cnt_reg;
        trunc_cnt_next = trunc_cnt_reg;
        if (drop_inc) begin
            drop_cnt_next = drop_cnt_reg + 32'd1;
        end
        if (trunc_inc) begin
            trunc_cnt_next = trunc_cnt_reg + 32'd1;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rx_reset) begin
            state_reg      <= S_IDLE;
            in_frame_reg   <= 1'b0;
            byte_cnt_reg   <= 16'd0;
            data_wren_reg  <= 1'b0;
            data_wdata_reg <= 73'd0;
            desc_pend_reg  <= 1'b0;
            desc_trunc_reg <= 1'b0;
            good_reg       <= 1'b0;
            ctrl_wren_reg  <= 1'b0;
            ctrl_wdata_reg <= 64'd0;
            seq_reg        <= 32'd0;
            drop_cnt_reg   <= 32'd0;
            trunc_cnt_reg  <= 32'd0;
        end else begin
            state_reg      <= state_next;
            in_frame_reg   <= in_frame_next;
            byte_cnt_reg   <= byte_cnt_next;
            data_wren_reg  <= data_wren_next;
            data_wdata_reg <= data_wdata_next;
            desc_pend_reg  <= desc_sched;
            desc_trunc_reg <= desc_trunc;
            good_reg       <= good_next;
            ctrl_wren_reg  <= ctrl_wren_next;
            ctrl_wdata_reg <= ctrl_wdata_next;
            seq_reg        <= seq_next;
            drop_cnt_reg   <= drop_cnt_next;
            trunc_cnt_reg  <= trunc_cnt_next;
        end
    end

    assign data_fifo_wren  = data_wren_reg;
    assign data_fifo_wdata = data_wdata_reg;
    assign ctrl_fifo_wren  = ctrl_wren_reg;
    assign ctrl_fifo_wdata = ctrl_wdata_reg;
    assign rx_drop_cnt     = drop_cnt_reg;
    assign rx_trunc_cnt    = trunc_cnt_reg;

endmodule

// File: tb/tb_ifm_in_fsm.sv
// Scoreboard bench for ifm_in_fsm: expected data beats and descriptors (value and arrival cycle)
// are queued as stimulus is driven and compared when the write strobes fire.
module tb_ifm_in_fsm;

    logic        rx_clk = 1'b0;
    logic        rx_reset;
    logic [63:0] rx_axis_mac_tdata;
    logic [7:0]  rx_axis_mac_tkeep;
    logic        rx_axis_mac_tvalid;
    logic        rx_axis_mac_tlast;
    logic        rx_axis_mac_tuser;
    logic [72:0] data_fifo_wdata;
    logic        data_fifo_wren;
    logic        data_fifo_full;
    logic        data_fifo_afull;
    logic [63:0] ctrl_fifo_wdata;
    logic        ctrl_fifo_wren;
    logic        ctrl_fifo_afull;
    logic [31:0] rx_drop_cnt;
    logic [31:0] rx_trunc_cnt;

    always #5 rx_clk = ~rx_clk;

    ifm_in_fsm #(.C_MAX_LEN(16'd9600)) dut (
        .rx_clk             (rx_clk),
        .rx_reset           (rx_reset),
        .rx_axis_mac_tdata  (rx_axis_mac_tdata),
        .rx_axis_mac_tkeep  (rx_axis_mac_tkeep),
        .rx_axis_mac_tvalid (rx_axis_mac_tvalid),
        .rx_axis_mac_tlast  (rx_axis_mac_tlast),
        .rx_axis_mac_tuser  (rx_axis_mac_tuser),
        .data_fifo_wdata    (data_fifo_wdata),
        .data_fifo_wren     (data_fifo_wren),
        .data_fifo_full     (data_fifo_full),
        .data_fifo_afull    (data_fifo_afull),
        .ctrl_fifo_wdata    (ctrl_fifo_wdata),
        .ctrl_fifo_wren     (ctrl_fifo_wren),
        .ctrl_fifo_afull    (ctrl_fifo_afull),
        .rx_drop_cnt        (rx_drop_cnt),
        .rx_trunc_cnt       (rx_trunc_cnt)
    );

    typedef struct {
        logic [72:0] val;
        int unsigned at;
    } exp_t;

    exp_t        data_q[$];
    exp_t        ctrl_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_seq = 0;
    logic [31:0] exp_drop = 0;
    logic [31:0] exp_trunc = 0;

    always @(posedge rx_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge rx_clk) begin : mon
        exp_t e;
        if (data_fifo_wren === 1'b1) begin
            if (data_q.size() == 0) begin
                check("data_unexpected", {72'd0, data_fifo_wren}, 73'd0);
            end else begin
                e = data_q.pop_front();
                check("data_val", data_fifo_wdata, e.val);
                check("data_cyc", 73'(cyc), 73'(e.at));
            end
        end
        if (ctrl_fifo_wren === 1'b1) begin
            $display("descriptor seq=%0d bytes=%0d flags=%b at cycle %0d",
                     ctrl_fifo_wdata[63:32], ctrl_fifo_wdata[15:0], ctrl_fifo_wdata[18:16], cyc);
            if (ctrl_q.size() == 0) begin
                check("desc_unexpected", {72'd0, ctrl_fifo_wren}, 73'd0);
            end else begin
                e = ctrl_q.pop_front();
                check("desc_val", {9'd0, ctrl_fifo_wdata}, e.val);
                check("desc_cyc", 73'(cyc), 73'(e.at));
            end
        end
    end

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic beat(input logic v, input logic [7:0] k, input logic l, input logic u,
                        input logic expw);
        exp_t e;
        logic [63:0] d;
        d = rnd64();
        rx_axis_mac_tvalid = v;
        rx_axis_mac_tdata  = d;
        rx_axis_mac_tkeep  = k;
        rx_axis_mac_tlast  = l;
        rx_axis_mac_tuser  = u;
        if (expw) begin
            e.val = {l, k, d};
            e.at  = cyc + 1;
            data_q.push_back(e);
        end
        @(posedge rx_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_data(input logic [72:0] v, input int unsigned at);
        exp_t e;
        e.val = v;
        e.at  = at;
        data_q.push_back(e);
    endtask

    task automatic push_desc(input logic [15:0] bytes, input logic good, input logic trunc,
                             input int unsigned at);
        exp_t e;
        logic over;
        over  = (bytes > 16'd9600);
        e.val = {9'd0, exp_seq, 13'd0, over, trunc, good, bytes};
        e.at  = at;
        ctrl_q.push_back(e);
        exp_seq++;
    endtask

    task automatic send_normal(input int n, input logic [7:0] last_keep, input logic user);
        logic [15:0] bytes;
        logic [7:0]  k;
        bytes = 0;
        $display("frame: %0d beats, last keep %h, tuser %0d", n, last_keep, user);
        for (int i = 0; i < n; i++) begin
            k = (i == n - 1) ? last_keep : 8'hFF;
            bytes = bytes + 16'($countones(k));
            if (i == n - 1) push_desc(bytes, user, 1'b0, cyc + 2);
            beat(1'b1, k, i == n - 1, user, 1'b1);
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_drop"}, 73'(rx_drop_cnt), 73'(exp_drop));
        check({tag, "_trunc"}, 73'(rx_trunc_cnt), 73'(exp_trunc));
    endtask

    initial begin
        rx_reset        = 1'b1;
        data_fifo_full  = 1'b0;
        data_fifo_afull = 1'b0;
        ctrl_fifo_afull = 1'b0;
        idle(3);
        check("rst_data_wren", 73'(data_fifo_wren), 73'd0);
        check("rst_ctrl_wren", 73'(ctrl_fifo_wren), 73'd0);
        check("rst_data_wdata", data_fifo_wdata, 73'd0);
        check("rst_ctrl_wdata", 73'(ctrl_fifo_wdata), 73'd0);
        check_counters("rst");
        rx_reset = 1'b0;
        idle(2);

        // normal 60-byte frame
        send_normal(8, 8'h0F, 1'b1);
        idle(4);

        // back-to-back single-beat frames
        send_normal(1, 8'hFF, 1'b0);
        send_normal(1, 8'hFF, 1'b0);
        idle(4);

        // admission drop, then a normal frame
        $display("frame: 10 beats dropped at admission");
        data_fifo_afull = 1'b1;
        beat(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
        data_fifo_afull = 1'b0;
        for (int i = 1; i < 10; i++) beat(1'b1, 8'hFF, i == 9, 1'b1, 1'b0);
        exp_drop++;
        idle(2);
        check_counters("adm_drop");
        send_normal(3, 8'h01, 1'b1);
        idle(4);

        // truncation: full on beat 4 of 10, released 3 cycles after tlast
        $display("frame: 10 beats truncated at beat 4");
        for (int i = 0; i < 3; i++) beat(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
        data_fifo_full = 1'b1;
        for (int i = 3; i < 10; i++) beat(1'b1, 8'hFF, i == 9, 1'b1, 1'b0);
        idle(2);
        data_fifo_full = 1'b0;
        push_data({1'b1, 8'h00, 64'h0}, cyc + 1);
        push_desc(16'd24, 1'b0, 1'b1, cyc + 2);
        exp_trunc++;
        idle(4);
        check_counters("trunc");

        // new frame arrives while waiting to write the terminator
        $display("frame: 4 beats truncated, next frame dropped during terminator wait");
        beat(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
        data_fifo_full = 1'b1;
        for (int i = 1; i < 4; i++) beat(1'b1, 8'hFF, i == 3, 1'b1, 1'b0);
        beat(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
        exp_drop++;
        data_fifo_full = 1'b0;
        push_data({1'b1, 8'h00, 64'h0}, cyc + 1);
        push_desc(16'd8, 1'b0, 1'b1, cyc + 2);
        exp_trunc++;
        beat(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
        beat(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
        send_normal(2, 8'h3F, 1'b1);
        idle(4);
        check_counters("term_sof");

        // oversize boundary: exactly C_MAX_LEN, then one beat more
        send_normal(1200, 8'hFF, 1'b1);
        send_normal(1201, 8'hFF, 1'b1);
        idle(4);

        // reset mid-frame: no terminator, no descriptor; tail becomes a new frame
        $display("frame: 3 beats then reset mid-frame");
        for (int i = 0; i < 3; i++) beat(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
        rx_reset = 1'b1;
        beat(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
        rx_reset = 1'b0;
        exp_seq   = 0;
        exp_drop  = 0;
        exp_trunc = 0;
        check("mid_rst_data_wren", 73'(data_fifo_wren), 73'd0);
        check("mid_rst_data_wdata", data_fifo_wdata, 73'd0);
        check("mid_rst_ctrl_wdata", 73'(ctrl_fifo_wdata), 73'd0);
        check_counters("mid_rst");
        beat(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
        push_desc(16'd11, 1'b1, 1'b0, cyc + 2);
        beat(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        idle(6);

        check("data_q_left", 73'(data_q.size()), 73'd0);
        check("ctrl_q_left", 73'(ctrl_q.size()), 73'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
